down_timer: RTL

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer_pkg.sv | 18 +
 rtl/down_timer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/down_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : down_timer_pkg
//  Purpose  : Shared state encoding and default width for the down_timer block.
//  Revision : 1.0 - initial release
// ============================================================================
package down_timer_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : down_timer_pkg
`default_nettype wire

// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : down_timer
//  Purpose  : Loadable N-bit down counter with one-shot or auto-reload modes,
//             a terminal-count pulse and an abort input.
//  Revision : 1.0 - initial release
// ============================================================================
module down_timer
    import down_timer_pkg::*;
#(
    parameter int N = c_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick_in,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         auto_reload,
    input  logic         stop,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done,
    output logic         zero_tick
);

    localparam logic [N-1:0] c_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] c_ZERO = '0;

    state_t         r_state;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_reload;
    logic           r_auto;
    logic           r_zero_tick;

    state_t         w_state_nxt;
    logic [N-1:0]   w_q_nxt;
    logic [N-1:0]   w_reload_nxt;
    logic           w_auto_nxt;
    logic           w_zero_tick_nxt;
    logic           w_terminal;

    // q<=1 is treated as terminal so the count can never wrap below zero
    assign w_terminal = (r_q <= c_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_q         <= c_ZERO;
            r_reload    <= c_ZERO;
            r_auto      <= 1'b0;
            r_zero_tick <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_q         <= w_q_nxt;
            r_reload    <= w_reload_nxt;
            r_auto      <= w_auto_nxt;
            r_zero_tick <= w_zero_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_q_nxt         = r_q;
        w_reload_nxt    = r_reload;
        w_auto_nxt      = r_auto;
        w_zero_tick_nxt = 1'b0;

        if (load) begin
            // load outranks stop and tick_in, and silently abandons any count
            w_reload_nxt = load_val;
            w_auto_nxt   = auto_reload;
            if (load_val != c_ZERO) begin
                w_q_nxt     = load_val;
                w_state_nxt = ST_RUN;
            end else begin
                w_q_nxt         = c_ZERO;
                w_state_nxt     = ST_DONE;
                w_zero_tick_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (tick_in) begin
                        if (!w_terminal) begin
                            w_q_nxt = r_q - c_ONE;
                        end else begin
                            w_zero_tick_nxt = 1'b1;
                            if (r_auto) begin
                                w_q_nxt = r_reload;
                            end else begin
                                w_q_nxt     = c_ZERO;
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    w_q_nxt = c_ZERO;
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    assign q         = r_q;
    assign zero_tick = r_zero_tick;

endmodule : down_timer
`default_nettype wire
